choose_from_n: RTL and testbench

- Clocked, parametrised successor to the two-way req/fin chooser.
- On a rising edge of req, it captures a channel select, drops fin, waits a fixed latency, then drives the selected channel's data onto out and raises fin.
- Adds M channels, configurable latency, optional output hold while busy, invalid-select error, and a one-deep pending request with overrun flag.
- Sits in the FlowControl path, between a requester and M data sources.

---
 rtl/choose_from_n_if.sv | 35 +++
 rtl/choose_from_n.sv | 126 ++++++++++++
 tb/tb_choose_from_n.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/choose_from_n_if.sv
// choose_from_n_if
//   Bundles the request/select/data/result signals of the channel chooser.
//   master : the requester side; drives req, sel and the packed channel data.
//   slave  : the chooser itself; returns out, fin, err and ovf.
//   Ports of the bundle:
//     req  - request level, a 0->1 transition starts a transaction
//     sel  - channel index (SW bits)
//     din  - packed channel data, channel i at din[i*N +: N]
//     out  - selected data (N bits)
//     fin  - high = idle/complete
//     err  - completed transaction had an out-of-range select
//     ovf  - sticky, a request was lost to overrun
interface choose_from_n_if #(
  parameter int N  = 32,
  parameter int M  = 4,
  parameter int SW = $clog2(M)
) ();
  logic              req;
  logic [SW-1:0]     sel;
  logic [N*M-1:0]    din;
  logic [N-1:0]      out;
  logic              fin;
  logic              err;
  logic              ovf;

  modport master (
    output req, sel, din,
    input  out, fin, err, ovf
  );

  modport slave (
    input  req, sel, din,
    output out, fin, err, ovf
  );
endinterface

// File: rtl/choose_from_n.sv
// choose_from_n
//   Clocked M-way chooser. A rising edge on req captures a channel index,
//   drops fin for LAT cycles, then registers that channel's data onto out and
//   raises fin. One further request may queue while busy; any more are lost
//   and flagged on the sticky ovf output.
//   Ports:
//     clk   - clock, all state changes on its rising edge
//     rst_n - asynchronous active-low reset
//     bus   - choose_from_n_if.slave (req/sel/din in, out/fin/err/ovf out)
module choose_from_n #(
  parameter int N        = 32,
  parameter int M        = 4,
  parameter int SW       = $clog2(M),
  parameter int LAT      = 1,
  parameter int CLR_BUSY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  choose_from_n_if.slave   bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_n;
  logic            req_q;
  logic            pend, pend_n;
  logic [7:0]      cnt, cnt_n;
  logic [SW-1:0]   sel_q, sel_q_n;
  logic [N-1:0]    out_q, out_n;
  logic            err_q, err_n;
  logic            ovf_q, ovf_n;
  logic            rise;
  logic            sel_ok;

  assign rise = bus.req & ~req_q;

  // When M fills the whole select range every index is legal, so the range
  // check collapses to a constant instead of a comparison that can never fail.
  if (M == (1 << SW)) begin : g_full_range
    assign sel_ok = 1'b1;
  end else begin : g_part_range
    assign sel_ok = (sel_q < SW'(M));
  end

  // State register. req_q resets high so a req held through reset must drop
  // and rise again before it counts as a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req_q <= 1'b1;
      pend  <= 1'b0;
      cnt   <= 8'd0;
      sel_q <= '0;
      out_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      req_q <= bus.req;
      pend  <= pend_n;
      cnt   <= cnt_n;
      sel_q <= sel_q_n;
      out_q <= out_n;
      err_q <= err_n;
      ovf_q <= ovf_n;
    end
  end

  // Next-state logic. In IDLE a queued request is served before a fresh rise,
  // and a rise arriving together with a queued request becomes the new queue
  // entry. In BUSY a rise queues, or is dropped with ovf if the queue is full;
  // this also applies on the completion edge so back-to-back work leaves fin
  // high for exactly one cycle.
  always_comb begin
    state_n = state;
    pend_n  = pend;
    cnt_n   = cnt;
    sel_q_n = sel_q;
    out_n   = out_q;
    err_n   = err_q;
    ovf_n   = ovf_q;
    case (state)
      IDLE: begin
        if (rise || pend) begin
          sel_q_n = bus.sel;
          cnt_n   = 8'(LAT - 1);
          err_n   = 1'b0;
          state_n = BUSY;
          pend_n  = pend ? rise : 1'b0;
          if (CLR_BUSY != 0) begin
            out_n = '0;
          end
        end
      end
      BUSY: begin
        if (rise) begin
          if (pend) begin
            ovf_n = 1'b1;
          end else begin
            pend_n = 1'b1;
          end
        end
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else begin
          // Data is sampled here, on the completion edge.
          if (sel_ok) begin
            out_n = bus.din[sel_q*N +: N];
            err_n = 1'b0;
          end else begin
            out_n = '0;
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.out = out_q;
  assign bus.fin = (state == IDLE);
  assign bus.err = err_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_choose_from_n.sv
// tb_choose_from_n
//   Directed bench for choose_from_n using two instances:
//     A: M=4, LAT=2, CLR_BUSY=1 - basic select, back-to-back requests
//     B: M=3, LAT=8, CLR_BUSY=0 - hold mode, invalid select, overrun, reset
module tb_choose_from_n;

  logic clk;
  logic rst_na;
  logic rst_nb;
  int   assertions;
  int   failures;

  choose_from_n_if #(.N(32), .M(4)) bus_a ();
  choose_from_n_if #(.N(32), .M(3)) bus_b ();

  choose_from_n #(.N(32), .M(4), .LAT(2), .CLR_BUSY(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_na),
    .bus   (bus_a)
  );

  choose_from_n #(.N(32), .M(3), .LAT(8), .CLR_BUSY(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_nb),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are sampled
  // and new inputs are applied.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulusA(input logic req, input logic [1:0] sel);
    bus_a.req = req;
    bus_a.sel = sel;
  endtask

  task automatic applyStimulusB(input logic req, input logic [1:0] sel);
    bus_b.req = req;
    bus_b.sel = sel;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    rst_na = 1'b0;
    rst_nb = 1'b0;
    bus_a.req = 1'b0;
    bus_a.sel = '0;
    bus_a.din = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    bus_b.req = 1'b0;
    bus_b.sel = '0;
    bus_b.din = {32'h33333333, 32'h22222222, 32'h11111111};
    #12;

    // ---- Instance A: reset values ----
    checkOutput("a_rst_out", bus_a.out, 32'h0);
    checkOutput("a_rst_fin", {31'b0, bus_a.fin}, 32'h1);
    checkOutput("a_rst_err", {31'b0, bus_a.err}, 32'h0);
    checkOutput("a_rst_ovf", {31'b0, bus_a.ovf}, 32'h0);
    rst_na = 1'b1;
    tick();

    // ---- A: basic select, sel=2, LAT=2 ----
    applyStimulusA(1'b1, 2'd2);
    tick();
    checkOutput("a_basic_fin0", {31'b0, bus_a.fin}, 32'h0);
    checkOutput("a_basic_out0", bus_a.out, 32'h0);
    applyStimulusA(1'b0, 2'd2);
    tick();
    checkOutput("a_basic_fin1", {31'b0, bus_a.fin}, 32'h0);
    checkOutput("a_basic_out1", bus_a.out, 32'h0);
    tick();
    checkOutput("a_basic_done", {31'b0, bus_a.fin}, 32'h1);
    checkOutput("a_basic_data", bus_a.out, 32'h33333333);
    checkOutput("a_basic_err", {31'b0, bus_a.err}, 32'h0);

    // ---- A: back-to-back, second rise lands on the completion edge ----
    applyStimulusA(1'b1, 2'd0);
    tick();
    applyStimulusA(1'b0, 2'd0);
    tick();
    applyStimulusA(1'b1, 2'd1);
    tick();
    checkOutput("a_b2b_fin_gap", {31'b0, bus_a.fin}, 32'h1);
    checkOutput("a_b2b_first", bus_a.out, 32'h11111111);
    applyStimulusA(1'b0, 2'd1);
    tick();
    checkOutput("a_b2b_fin_low0", {31'b0, bus_a.fin}, 32'h0);
    tick();
    checkOutput("a_b2b_fin_low1", {31'b0, bus_a.fin}, 32'h0);
    tick();
    checkOutput("a_b2b_fin_done", {31'b0, bus_a.fin}, 32'h1);
    checkOutput("a_b2b_second", bus_a.out, 32'h22222222);
    checkOutput("a_b2b_ovf", {31'b0, bus_a.ovf}, 32'h0);

    // ---- Instance B: reset values ----
    checkOutput("b_rst_out", bus_b.out, 32'h0);
    checkOutput("b_rst_fin", {31'b0, bus_b.fin}, 32'h1);
    rst_nb = 1'b1;
    tick();

    // ---- B: first transaction sel=2, LAT=8, hold mode ----
    applyStimulusB(1'b1, 2'd2);
    tick();
    checkOutput("b_t1_fin0", {31'b0, bus_b.fin}, 32'h0);
    applyStimulusB(1'b0, 2'd2);
    repeat (7) tick();
    checkOutput("b_t1_fin_last", {31'b0, bus_b.fin}, 32'h0);
    tick();
    checkOutput("b_t1_fin", {31'b0, bus_b.fin}, 32'h1);
    checkOutput("b_t1_out", bus_b.out, 32'h33333333);

    // ---- B: hold mode keeps out while busy ----
    applyStimulusB(1'b1, 2'd0);
    tick();
    checkOutput("b_hold_fin0", {31'b0, bus_b.fin}, 32'h0);
    checkOutput("b_hold_out0", bus_b.out, 32'h33333333);
    applyStimulusB(1'b0, 2'd0);
    repeat (7) tick();
    checkOutput("b_hold_out7", bus_b.out, 32'h33333333);
    tick();
    checkOutput("b_hold_done", bus_b.out, 32'h11111111);

    // ---- B: invalid select sel=3 with M=3 ----
    applyStimulusB(1'b1, 2'd3);
    tick();
    applyStimulusB(1'b0, 2'd3);
    repeat (8) tick();
    checkOutput("b_inv_fin", {31'b0, bus_b.fin}, 32'h1);
    checkOutput("b_inv_out", bus_b.out, 32'h0);
    checkOutput("b_inv_err", {31'b0, bus_b.err}, 32'h1);
    applyStimulusB(1'b1, 2'd1);
    tick();
    checkOutput("b_inv_clr_err", {31'b0, bus_b.err}, 32'h0);
    checkOutput("b_inv_clr_fin", {31'b0, bus_b.fin}, 32'h0);
    applyStimulusB(1'b0, 2'd1);
    repeat (8) tick();
    checkOutput("b_inv_next_out", bus_b.out, 32'h22222222);

    // ---- B: overrun, three rises in one busy window ----
    applyStimulusB(1'b1, 2'd2);
    tick();
    applyStimulusB(1'b0, 2'd0);
    tick();
    applyStimulusB(1'b1, 2'd0);
    tick();
    checkOutput("b_ovr_pend_only", {31'b0, bus_b.ovf}, 32'h0);
    applyStimulusB(1'b0, 2'd0);
    tick();
    applyStimulusB(1'b1, 2'd0);
    tick();
    checkOutput("b_ovr_set", {31'b0, bus_b.ovf}, 32'h1);
    applyStimulusB(1'b0, 2'd0);
    tick();
    applyStimulusB(1'b1, 2'd0);
    tick();
    applyStimulusB(1'b0, 2'd0);
    tick();
    tick();
    checkOutput("b_ovr_t1_fin", {31'b0, bus_b.fin}, 32'h1);
    checkOutput("b_ovr_t1_out", bus_b.out, 32'h33333333);
    tick();
    checkOutput("b_ovr_t2_start", {31'b0, bus_b.fin}, 32'h0);
    repeat (8) tick();
    checkOutput("b_ovr_t2_fin", {31'b0, bus_b.fin}, 32'h1);
    checkOutput("b_ovr_t2_out", bus_b.out, 32'h11111111);
    repeat (3) tick();
    checkOutput("b_ovr_no_third", {31'b0, bus_b.fin}, 32'h1);
    checkOutput("b_ovr_sticky", {31'b0, bus_b.ovf}, 32'h1);

    // ---- B: reset at cnt=1, then req held high through release ----
    applyStimulusB(1'b1, 2'd1);
    tick();
    applyStimulusB(1'b0, 2'd1);
    repeat (6) tick();
    checkOutput("b_mid_fin", {31'b0, bus_b.fin}, 32'h0);
    checkOutput("b_mid_out", bus_b.out, 32'h11111111);
    rst_nb = 1'b0;
    #1;
    checkOutput("b_rst_mid_out", bus_b.out, 32'h0);
    checkOutput("b_rst_mid_fin", {31'b0, bus_b.fin}, 32'h1);
    checkOutput("b_rst_mid_ovf", {31'b0, bus_b.ovf}, 32'h0);
    applyStimulusB(1'b1, 2'd1);
    tick();
    rst_nb = 1'b1;
    repeat (3) tick();
    checkOutput("b_held_req_idle", {31'b0, bus_b.fin}, 32'h1);
    applyStimulusB(1'b0, 2'd1);
    tick();
    applyStimulusB(1'b1, 2'd1);
    tick();
    checkOutput("b_new_rise_start", {31'b0, bus_b.fin}, 32'h0);
    applyStimulusB(1'b0, 2'd1);
    repeat (8) tick();
    checkOutput("b_new_rise_out", bus_b.out, 32'h22222222);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
